// File: rtl/ttl_mux_arbiter_if.sv
`timescale 1ns/1ps
// Purpose: bundles the requester-facing signals of the shared 74x153 mux arbiter.
// Latency: none (wires only).
// Backpressure: none; requesters hold req until they see their grant bit.
// Signals:
//   req      [3:0] request per requester, bit i asks for mux input i
//   grant    [3:0] one-hot grant, 0000 when no owner
//   sel      [1:0] mux select {b,a}
//   enable_n       active-low strobe to both G pins
//   busy           arbiter is settling or granting
interface ttl_mux_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       enable_n;
  logic       busy;

  // Requester side
  modport master (output req, input grant, input sel, input enable_n, input busy);
  // Arbiter side
  modport slave  (input req, output grant, output sel, output enable_n, output busy);
endinterface

// File: rtl/ttl_mux_arbiter.sv
`timescale 1ns/1ps
// Purpose: round-robin arbiter sharing one dual 4-to-1 mux among 4 requesters with break-before-make.
// Latency: req seen at edge N -> sel after N, grant/enable_n low after N + SETTLE_CYCLES.
// Backpressure: requesters wait by holding req; the owner is preempted after MAX_HOLD cycles if others wait.
// Ports: clk, rst_n (async active-low), bus (ttl_mux_arbiter_if.slave: req, grant, sel, enable_n, busy),
//        lock (only with TTL_MUX_ARB_LOCK_EN defined: suppresses preemption while granting).
// Optional macro: TTL_MUX_ARB_LOCK_EN.
module ttl_mux_arbiter #(
  parameter int MAX_HOLD      = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef TTL_MUX_ARB_LOCK_EN
  input  logic lock,
`endif
  ttl_mux_arbiter_if.slave bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(MAX_HOLD);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    last_q, last_d;
  logic [3:0]    grant_q, grant_d;
  logic          enable_n_q, enable_n_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] settle_q, settle_d;

  logic [1:0]    pick_idx;
  logic          pick_vld;
  logic [1:0]    scan_idx;
  logic [3:0]    owner_oh;
  logic          others_req;
  logic          preempt_ok;

  // Round-robin search starting just after the last owner, wrapping at 4.
  always_comb begin
    pick_idx = 2'd0;
    pick_vld = 1'b0;
    scan_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = last_q + 2'(k + 1);
      if (!pick_vld && bus.req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign owner_oh   = 4'b0001 << sel_q;
  assign others_req = |(bus.req & ~owner_oh);
`ifdef TTL_MUX_ARB_LOCK_EN
  assign preempt_ok = !lock;
`else
  assign preempt_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    grant_d    = grant_q;
    enable_n_d = enable_n_q;
    hold_d     = hold_q;
    settle_d   = settle_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel_d    = pick_idx;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        // Pointer is left alone on abort so the aborted requester keeps its turn.
        if (!bus.req[sel_q]) begin
          state_d = IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          grant_d    = owner_oh;
          enable_n_d = 1'b0;
          hold_d     = HW'(1);
          state_d    = GRANT;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      GRANT: begin
        // Release and preempt share one exit path, so a coincident pair is one release.
        if (!bus.req[sel_q] || (hold_q == HOLD_MAX && others_req && preempt_ok)) begin
          grant_d    = 4'b0000;
          enable_n_d = 1'b1;
          last_d     = sel_q;
          hold_d     = '0;
          state_d    = IDLE;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = 4'b0000;
        enable_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      last_q     <= 2'd3;
      grant_q    <= 4'b0000;
      enable_n_q <= 1'b1;
      hold_q     <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      enable_n_q <= enable_n_d;
      hold_q     <= hold_d;
      settle_q   <= settle_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.enable_n = enable_n_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ttl_mux_arbiter.sv
`timescale 1ns/1ps
module tb_ttl_mux_arbiter;

  logic clk;
  logic rst_n;
  logic lock;
  int   checks;
  int   failures;

  logic [3:0] exp_q[$];
  logic [3:0] prev_grant;
  logic       prev_en_n;
  logic [1:0] prev_sel;

  ttl_mux_arbiter_if bus ();

  ttl_mux_arbiter #(.MAX_HOLD(4), .SETTLE_CYCLES(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef TTL_MUX_ARB_LOCK_EN
    .lock  (lock),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard and invariant monitor, sampled on the falling edge.
  initial begin
    prev_grant = 4'b0000;
    prev_en_n  = 1'b1;
    prev_sel   = 2'd0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("inv_en_vs_grant", {7'd0, bus.enable_n}, {7'd0, (bus.grant == 4'b0000)});
        chk("inv_onehot0", {7'd0, $onehot0(bus.grant)}, 8'd1);
        if (!prev_en_n && !bus.enable_n)
          chk("inv_sel_stable", {6'd0, bus.sel}, {6'd0, prev_sel});
        if (prev_grant == 4'b0000 && bus.grant != 4'b0000) begin
          if (exp_q.size() == 0)
            chk("sb_unexpected_grant", {4'd0, bus.grant}, 8'd0);
          else
            chk("sb_grant", {4'd0, bus.grant}, {4'd0, exp_q.pop_front()});
        end
      end
      prev_grant = bus.grant;
      prev_en_n  = bus.enable_n;
      prev_sel   = bus.sel;
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    lock     = 1'b0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    #12;
    chk("rst_grant", {4'd0, bus.grant}, 8'h00);
    chk("rst_sel", {6'd0, bus.sel}, 8'h00);
    chk("rst_en_n", {7'd0, bus.enable_n}, 8'h01);
    chk("rst_busy", {7'd0, bus.busy}, 8'h00);
    rst_n = 1'b1;
    step(1);

    // Single request, latency check.
    bus.req = 4'b0100; exp_q.push_back(4'b0100);
    step(1);
    chk("single_sel", {6'd0, bus.sel}, 8'h02);
    chk("single_en_n_settle", {7'd0, bus.enable_n}, 8'h01);
    chk("single_busy", {7'd0, bus.busy}, 8'h01);
    chk("single_grant_settle", {4'd0, bus.grant}, 8'h00);
    step(1);
    chk("single_grant", {4'd0, bus.grant}, 8'h04);
    chk("single_en_n", {7'd0, bus.enable_n}, 8'h00);
    bus.req = 4'b0000;
    step(1);
    chk("single_release", {4'd0, bus.grant}, 8'h00);

    // Owner 1 release.
    bus.req = 4'b0010; exp_q.push_back(4'b0010);
    step(2);
    chk("own1_grant", {4'd0, bus.grant}, 8'h02);
    chk("own1_sel", {6'd0, bus.sel}, 8'h01);
    bus.req = 4'b0000;
    step(1);
    chk("own1_rel_grant", {4'd0, bus.grant}, 8'h00);
    chk("own1_rel_en_n", {7'd0, bus.enable_n}, 8'h01);
    step(1);

    // Abort during SETTLE: pointer stays at 1, so 1001 must pick requester 3.
    bus.req = 4'b1000;
    step(1);
    chk("abort_sel", {6'd0, bus.sel}, 8'h03);
    chk("abort_busy_settle", {7'd0, bus.busy}, 8'h01);
    bus.req = 4'b0000;
    step(1);
    chk("abort_busy_idle", {7'd0, bus.busy}, 8'h00);
    chk("abort_grant", {4'd0, bus.grant}, 8'h00);
    chk("abort_sel_hold", {6'd0, bus.sel}, 8'h03);
    step(1);
    bus.req = 4'b1001; exp_q.push_back(4'b1000);
    step(2);
    chk("abort_next_grant", {4'd0, bus.grant}, 8'h08);
    bus.req = 4'b0000;
    step(2);

    // Round robin with all requesting, pointer now at 3.
    bus.req = 4'b1111;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    step(2);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("rr%0d_grant_c%0d", g, c), {4'd0, bus.grant}, 8'(1 << (g % 4)));
        chk($sformatf("rr%0d_sel_c%0d", g, c), {6'd0, bus.sel}, 8'(g % 4));
        step(1);
      end
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("rr%0d_gap_c%0d", g, c), {3'd0, bus.enable_n, bus.grant}, 8'h10);
        step(1);
      end
    end
    chk("rr6_grant", {4'd0, bus.grant}, 8'h02);
    step(1);

    // Asynchronous reset mid-grant.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", {4'd0, bus.grant}, 8'h00);
    chk("arst_sel", {6'd0, bus.sel}, 8'h00);
    chk("arst_en_n", {7'd0, bus.enable_n}, 8'h01);
    chk("arst_busy", {7'd0, bus.busy}, 8'h00);
    chk("arst_sb_empty", 8'(exp_q.size()), 8'd0);
    exp_q.push_back(4'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    chk("arst_first_grant", {4'd0, bus.grant}, 8'h01);

    // No competitor: owner 0 drops, requester 1 holds alone.
    bus.req = 4'b0010; exp_q.push_back(4'b0010);
    step(3);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("solo_grant_c%0d", c), {4'd0, bus.grant}, 8'h02);
      chk($sformatf("solo_sel_c%0d", c), {6'd0, bus.sel}, 8'h01);
      step(1);
    end
    bus.req = 4'b0000;
    step(1);
    chk("solo_release", {4'd0, bus.grant}, 8'h00);
    step(1);

`ifdef TTL_MUX_ARB_LOCK_EN
    // Lock suppresses preemption; pointer at 1 so 0011 picks requester 0.
    lock = 1'b1;
    bus.req = 4'b0011; exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    step(2);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("lock_grant_c%0d", c), {4'd0, bus.grant}, 8'h01);
      step(1);
    end
    lock = 1'b0;
    step(1);
    chk("lock_preempt", {4'd0, bus.grant}, 8'h00);
    step(1);
    chk("lock_gap", {4'd0, bus.grant}, 8'h00);
    step(1);
    chk("lock_next", {4'd0, bus.grant}, 8'h02);
    bus.req = 4'b0000;
    step(2);
`endif

    chk("sb_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
